// File: rtl/rfdp_fifo_ctrl.sv
// rfdp_fifo_ctrl: valid/ready stream FIFO built around a 1W/1R register-file SRAM.
// Writes go straight to the SRAM port B. Reads are prefetched through port A into a
// 2-entry output buffer that hides the SRAM's 1-cycle read latency.
module rfdp_fifo_ctrl #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW+1:0]    count,
   output logic [AW-1:0]    sram_ab,
   output logic [WIDTH-1:0] sram_db,
   output logic             sram_cenb,
   output logic [AW-1:0]    sram_aa,
   output logic             sram_cena,
   input  logic [WIDTH-1:0] sram_qa
);

   localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      sram_cnt_q, sram_cnt_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       buf_cnt_q, buf_cnt_d;
   logic [WIDTH-1:0] buf0_q, buf0_d;
   logic [WIDTH-1:0] buf1_q, buf1_d;
   logic [AW+1:0]    count_q, count_d;
   logic             rd_valid_q, rd_valid_d;

   logic             wr_hs;
   logic             rd_hs;
   logic             issue;
   logic             push;
   logic [2:0]       occ;
   logic [1:0]       widx;

   // Handshakes, read-issue decision and SRAM port drive
   always_comb begin
      wr_ready  = ~rst & ~clr & (sram_cnt_q != FullCnt);
      wr_hs     = wr_valid & wr_ready;
      rd_hs     = rd_valid_q & rd_ready & ~rst & ~clr;
      // Buffer slots that will be committed after this cycle, counting the word in flight
      occ       = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, rd_hs};
      issue     = ~rst & ~clr & (sram_cnt_q != '0) & (occ < 3'd2);
      push      = inflight_q & ~rst & ~clr;
      sram_cenb = ~wr_hs;
      sram_ab   = wptr_q;
      sram_db   = wr_data;
      sram_cena = ~issue;
      sram_aa   = rptr_q;
   end

   // Next-state for pointers, occupancy and the output buffer
   always_comb begin
      wptr_d     = wr_hs ? wptr_q + AW'(1) : wptr_q;
      rptr_d     = issue ? rptr_q + AW'(1) : rptr_q;
      sram_cnt_d = sram_cnt_q + (AW+1)'(wr_hs) - (AW+1)'(issue);
      inflight_d = issue;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      // Pop shifts the second entry to the head before the returning word lands
      if (rd_hs) begin
         buf0_d = buf1_q;
      end
      widx = buf_cnt_q - {1'b0, rd_hs};
      if (push) begin
         if (widx == 2'd0) begin
            buf0_d = sram_qa;
         end else begin
            buf1_d = sram_qa;
         end
      end
      buf_cnt_d  = buf_cnt_q + {1'b0, push} - {1'b0, rd_hs};
      count_d    = {1'b0, sram_cnt_d} + (AW+2)'(inflight_d) + (AW+2)'(buf_cnt_d);
      rd_valid_d = (buf_cnt_d != 2'd0);
   end

   // State registers: rst clears everything, clr empties the FIFO but keeps data regs
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
         buf_cnt_q  <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else if (clr) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
         buf_cnt_q  <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         sram_cnt_q <= sram_cnt_d;
         inflight_q <= inflight_d;
         buf_cnt_q  <= buf_cnt_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Registered stream outputs
   always_comb begin
      rd_valid = rd_valid_q;
      rd_data  = buf0_q;
      count    = count_q;
   end

endmodule

// File: doc/rfdp_fifo_ctrl.md
# rfdp_fifo_ctrl

Synchronous FIFO controller that turns one `rfdp<D>x<W>` 1-write/1-read register-file SRAM into a valid/ready stream FIFO. It sits directly in front of the SRAM wrapper: it generates `AB/DB/CENB` on the write side and `AA/CENA` on the read side, absorbs the SRAM's 1-cycle read latency, and presents a full-throughput output stream. In the CNN datapath it buffers feature-map and weight streams between producers and the PE array.

## Interface
- `DEPTH`, 1024: SRAM word count. Power of two, ≥ 4.
- `WIDTH`, 16: data width in bits.
- `AW`, `$clog2(DEPTH)`: SRAM address width. Derived; do not override.
- `clk`  in  1  single clock; drives the SRAM `CLKA` and `CLKB` as well.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous flush; empties the FIFO without resetting the rest of the logic.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  space available.
- `wr_data`  in  WIDTH  write data.
- `rd_valid`  out  1  head entry valid.
- `rd_ready`  in  1  consumer accepts head.
- `rd_data`  out  WIDTH  head entry.
- `count`  out  AW+2  total entries held: SRAM + in-flight read + output buffer.
- `sram_ab`  out  AW  write address, to SRAM `AB`.
- `sram_db`  out  WIDTH  write data, to SRAM `DB`.
- `sram_cenb`  out  1  write enable, active low, to SRAM `CENB`.
- `sram_aa`  out  AW  read address, to SRAM `AA`.
- `sram_cena`  out  1  read enable, active low, to SRAM `CENA`.
- `sram_qa`  in  WIDTH  read data from SRAM `QA`. Valid the cycle after `sram_cena` is low.

## Operation
- **Write side:**
  - A handshake occurs when `wr_valid && wr_ready`. In that cycle the block drives `sram_cenb=0`, `sram_ab=wptr` and `sram_db=wr_data` combinationally.
  - `wptr` increments mod DEPTH. `sram_cnt` increments at the clock edge.
  - `wr_ready = (sram_cnt != DEPTH)`. The signal is independent of `wr_valid`.
- **Read prefetch:**
  - A read is issued (`sram_cena=0`, `sram_aa=rptr`) when `sram_cnt != 0` and `buf_cnt + inflight + (rd handshake this cycle ? -1 : 0) < 2`.
  - On issue, `rptr` increments, `sram_cnt` decrements and `inflight` is set to 1.
  - A simultaneous write and read-issue leaves `sram_cnt` unchanged.
  - Address collision is impossible: reads only target words whose write completed in an earlier cycle.
- **Output buffer:**
  - 2-entry register FIFO. When `inflight=1`, `sram_qa` is pushed into it at the clock edge and `inflight` clears, unless a new read is issued that cycle.
  - `rd_valid = (buf_cnt != 0)`; `rd_data` is the head entry.
  - The buffer never overflows, because of the issue rule above.
- **Count:** `count = sram_cnt + inflight + buf_cnt`. Maximum value is DEPTH+2.
- **Flush:** `clr=1` zeroes `wptr`, `rptr`, `sram_cnt`, `buf_cnt` and `inflight`.
  - Any `sram_qa` returned in the cycle after `clr` is discarded.
  - While `clr=1`: `wr_ready=0`, no SRAM access, and `rd_valid` reads 0 in the following cycle.
- **Reset:** `rst` has the same effect as `clr`, plus it clears the output data registers.
- **Priority:** `rst` over `clr` over normal operation.
- Data is never reordered, duplicated or dropped except by `clr`/`rst`.

## Timing
- **Reset values:**
  - `wr_ready=0` while `rst=1`, and 1 from the first cycle after.
  - `rd_valid=0`, `rd_data=0`, `count=0`.
  - `sram_cena=1`, `sram_cenb=1`, `sram_aa=0`, `sram_ab=0`.
- **Fall-through latency:** a write handshake in cycle t into an empty FIFO gives read issue in t+1, `sram_qa` valid in t+2, and `rd_valid=1` in t+3.
- **Throughput:** sustained 1 write + 1 read per cycle with `rd_ready` held high and no bubbles once primed.
- **Full:** `wr_ready` drops the cycle after the write that makes `sram_cnt=DEPTH`. It rises the cycle after the next read issue.
- **Output back-pressure:** with `rd_ready=0`, the buffer fills to 2 and issue stops. Held entries stay stable: `rd_data` must not change while `rd_valid && !rd_ready`.
- **Pointer wrap:** `wptr`/`rptr` wrap DEPTH-1→0 with no bubble.
- **Registered outputs:** `count`, `rd_valid` and `rd_data` are registered. All `sram_*` outputs are combinational from registered state plus `wr_valid`/`rd_ready`.

## Test plan
- **Fall-through:** reset, then write 0xA5A5 at cycle 0 with `rd_ready=1`. Required: `sram_cenb=0`, `sram_ab=0` at cycle 0; `sram_cena=0`, `sram_aa=0` at cycle 1; `rd_valid=1`, `rd_data=0xA5A5` at cycle 3; `count` goes 1,1,1,0.
- **Fill:** DEPTH=16, `rd_ready=0`, write 0..19 continuously. Required: 18 words accepted, `wr_ready=0` after, `count=18`, 2 read issues only. Then `rd_ready=1` drains 0..17 in order and `count` returns to 0.
- **Streaming wrap:** `wr_valid=rd_ready=1` for 3·DEPTH cycles with an incrementing pattern. Required: output is in order, one word per cycle after the 3-cycle prime, and `sram_aa`/`sram_ab` each wrap 3 times.
- **Random back-pressure:** random `wr_valid`/`rd_ready` at 50% for 10k cycles against a scoreboard model. Required: zero mismatches, `count` always matches the model, `rd_data` stable while stalled.
- **Flush mid-read:** with `count=5` and a read in flight, pulse `clr` for 1 cycle. Required: `count=0` and `rd_valid=0` next cycle, the stale `sram_qa` is not delivered, and a subsequent write 0x1234 emerges at `rd_data` after 3 cycles.
- **Reset mid-operation:** assert `rst` at half-full during streaming. Required: all outputs at reset values the next cycle, `wr_ready=1` the cycle after `rst` falls.
